// File: rtl/soc_pkg.sv
// Shared definitions for the IMEM reload sequencer: FSM state encoding and the
// frame start marker.
package soc_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN0  = 3'd1,
    LDR_LEN1  = 3'd2,
    LDR_DATA  = 3'd3,
    LDR_WRITE = 3'd4,
    LDR_CSUM  = 3'd5,
    LDR_DONE  = 3'd6
  } imem_ldr_state_t;

  localparam logic [7:0] IMEM_LDR_SYNC = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// Reloads CPU instruction memory from a byte stream: holds the CPU in reset,
// packs little-endian words, writes them to IMEM, checks the sum, releases the CPU.
module imem_loader
  import soc_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned NUM_WORDS_IMEM = 8192,
  parameter int unsigned TIMEOUT_CYC    = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_vld,
  output logic            rx_rdy,
  input  logic [7:0]      rx_dat,
  output logic            imem_cpu_rstn,
  output logic            imem_we,
  output logic [29:0]     imem_waddr,
  output logic [31:0]     imem_wdat,
  output logic            busy,
  output logic            err,
  output imem_ldr_state_t state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Handshake: a byte transfers on a rising edge where rx_vld & rx_rdy are both
  // high; rx_dat must be stable while rx_vld is high and rx_rdy is low.

  imem_ldr_state_t state_q, state_d;
  logic            rdy_q;
  logic            err_q, busy_q, rstn_q;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [15:0]     len_in;
  logic [15:0]     word_idx;
  logic [1:0]      byte_cnt;
  logic [31:0]     buffer;
  logic [7:0]      csum;
  logic [29:0]     waddr_q;
  logic [TW-1:0]   tcnt;
  logic            accept;
  logic            timeout;
  logic            fail;

  assign accept        = rx_vld & rx_rdy;
  assign len_in        = {rx_dat, len_lo};
  assign rx_rdy        = rdy_q;
  assign imem_cpu_rstn = rstn_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign imem_we       = (state_q == LDR_WRITE);
  assign imem_waddr    = waddr_q;
  assign imem_wdat     = buffer;
  assign state         = state_q;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    fail    = 1'b0;
    case (state_q)
      LDR_IDLE:  if (accept && rx_dat == IMEM_LDR_SYNC) state_d = LDR_LEN0;
      LDR_LEN0:  if (accept) state_d = LDR_LEN1;
      LDR_LEN1: begin
        if (accept) begin
          if (len_in == 16'd0)                           state_d = LDR_CSUM;
          else if ({16'd0, len_in} > 32'(NUM_WORDS_IMEM)) state_d = LDR_IDLE;
          else                                           state_d = LDR_DATA;
        end
      end
      LDR_DATA:  if (accept && byte_cnt == 2'd3) state_d = LDR_WRITE;
      LDR_WRITE: state_d = (word_idx == len - 16'd1) ? LDR_CSUM : LDR_DATA;
      LDR_CSUM:  if (accept) state_d = (rx_dat == csum) ? LDR_DONE : LDR_IDLE;
      LDR_DONE:  state_d = LDR_IDLE;
      default:   state_d = LDR_IDLE;
    endcase
    // The idle window closes on the cycle that would make it TIMEOUT_CYC long.
    if (state_q != LDR_IDLE && !accept && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      timeout = 1'b1;
      state_d = LDR_IDLE;
    end
    // Any return to IDLE other than through DONE is an aborted frame.
    fail = (state_d == LDR_IDLE) && (state_q != LDR_IDLE) && (state_q != LDR_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rstn_q   <= 1'b1;
      len_lo   <= '0;
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      buffer   <= '0;
      csum     <= '0;
      waddr_q  <= ADDR_BASE[31:2];
      tcnt     <= '0;
    end else begin
      // Registered so it is low exactly while the write cycle is occupying the FSM.
      rdy_q <= (state_d != LDR_WRITE);
      tcnt  <= (state_q == LDR_IDLE || accept || timeout) ? '0 : tcnt + TW'(1);
      case (state_q)
        LDR_IDLE: begin
          if (accept && rx_dat == IMEM_LDR_SYNC) begin
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            rstn_q   <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            waddr_q  <= ADDR_BASE[31:2];
          end
        end
        LDR_LEN0: if (accept) len_lo <= rx_dat;
        LDR_LEN1: if (accept) len <= len_in;
        LDR_DATA: begin
          if (accept) begin
            buffer   <= {rx_dat, buffer[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum + rx_dat;
          end
        end
        LDR_WRITE: begin
          word_idx <= word_idx + 16'd1;
          waddr_q  <= waddr_q + 30'd1;
        end
        LDR_DONE: begin
          rstn_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
      if (fail) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

endmodule
